// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and round-robin pick helper for the uart_tx arbiter
package uart_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int PTR_W = $clog2(MAX_REQ);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE} state_t;
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [PTR_W-1:0] ptr, input int n);
    int idx;
    logic found;
    rr_pick = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && valid[idx[PTR_W-1:0]]) begin
        rr_pick[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector, first valid index at or after ptr
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx
);
  assign onehot = N_REQ'(rr_pick(MAX_REQ'(valid), PTR_W'(ptr), N_REQ));
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) idx = onehot[i] ? PW'(i) : idx;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx between N_REQ requesters
// Optional idle-owner timeout release enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               uart_tx_start,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_idle,
  output logic               busy,
  output logic               timeout
);
  localparam int PW = $clog2(N_REQ);
  state_t state, state_n;
  logic [PW-1:0] ptr, gidx, pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic last_q, xfer, release_g, tmo_fire;
  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid(req_valid),
    .ptr(ptr),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  assign req_ready = (state == LOAD && uart_tx_idle) ? (req_valid & grant) : '0;
  assign xfer = |req_ready;
  assign busy = state != IDLE;
  assign release_g = (state == WAIT_IDLE && uart_tx_idle && last_q) || tmo_fire;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] stall_cnt;
  assign tmo_fire = state == LOAD && stall_cnt == CW'(TIMEOUT_CYC);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else stall_cnt <= (xfer || tmo_fire) ? '0 : (state == LOAD && !req_valid[gidx]) ? stall_cnt + 1'b1 : stall_cnt;
  end
`else
  assign tmo_fire = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = |req_valid ? LOAD : IDLE;
      LOAD:      state_n = tmo_fire ? IDLE : xfer ? SEND : LOAD;
      SEND:      state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = uart_tx_idle ? WAIT_BUSY : WAIT_IDLE;
      WAIT_IDLE: state_n = !uart_tx_idle ? WAIT_IDLE : last_q ? IDLE : LOAD;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      ptr <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_data <= 8'h00;
      last_q <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      uart_tx_start <= xfer;
      timeout <= tmo_fire;
      if (xfer) begin
        uart_tx_data <= req_data[8*gidx +: 8];
        last_q <= req_last[gidx];
      end
      if (state == IDLE && |req_valid) begin
        grant <= pick_oh;
        gidx <= pick_idx;
      end else if (release_g) begin
        grant <= '0;
        ptr <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a small uart_tx timing model
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_last = '0;
  logic [3:0] req_ready, grant;
  logic uart_tx_start, uart_tx_idle, busy, timeout;
  logic [7:0] uart_tx_data;
  logic [3:0] ucnt;
  logic [3:0] hs = '0;
  logic [3:0] en = 4'b1111;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [3:0] g; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  logic [8:0] rq[4][$];
  typedef struct {logic [3:0] mask; int ord[4]; int n;} vec_t;
  vec_t tbl[6];

  uart_tx_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant(grant),
    .uart_tx_start(uart_tx_start),
    .uart_tx_data(uart_tx_data),
    .uart_tx_idle(uart_tx_idle),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ucnt <= '0;
    else if (uart_tx_start) ucnt <= 4'd4;
    else if (ucnt != 0) ucnt <= ucnt - 1'b1;
  end
  assign uart_tx_idle = ucnt == 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic expect_byte(input int idx, input logic [7:0] d);
    exp_q.push_back({4'(1 << idx), d});
  endtask

  function automatic int pending();
    return rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size();
  endfunction

  task automatic tick();
    exp_t e;
    logic ok;
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    ok = $onehot0(grant) && ((req_ready & ~grant) == 4'b0) && !timeout;
    chk("invariant", 32'(ok), 32'd1);
    if (uart_tx_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: got data=%h grant=%b expected no start", uart_tx_data, grant);
      end else begin
        e = exp_q.pop_front();
        if (uart_tx_data !== e.d || grant !== e.g) begin
          errors++;
          $display("FAIL scoreboard: got data=%h grant=%b expected data=%h grant=%b", uart_tx_data, grant, e.d, e.g);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = en[i] && rq[i].size() > 0;
      req_data[8*i +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      req_last[i] = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
    end
    #1;
    hs = req_valid & req_ready;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy || pending() != 0) && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk({name, "_done"}, 32'(cyc < 2000), 32'd1);
    chk({name, "_grant_idle"}, 32'(grant), 32'd0);
  endtask

  initial begin
    tbl[0] = '{mask: 4'b0101, ord: '{0, 2, 0, 0}, n: 2};
    tbl[1] = '{mask: 4'b0101, ord: '{0, 2, 0, 0}, n: 2};
    tbl[2] = '{mask: 4'b1111, ord: '{3, 0, 1, 2}, n: 4};
    tbl[3] = '{mask: 4'b0110, ord: '{1, 2, 0, 0}, n: 2};
    tbl[4] = '{mask: 4'b1000, ord: '{3, 0, 0, 0}, n: 1};
    tbl[5] = '{mask: 4'b0011, ord: '{0, 1, 0, 0}, n: 2};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_start", 32'(uart_tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // one requester, three-byte packet
    foreach (rq[i]) rq[i] = {};
    rq[1].push_back({1'b0, 8'h41});
    rq[1].push_back({1'b0, 8'h42});
    rq[1].push_back({1'b1, 8'h43});
    expect_byte(1, 8'h41);
    expect_byte(1, 8'h42);
    expect_byte(1, 8'h43);
    wait_done("single");

    // pointer now 2: req 2 must beat req 0
    rq[0].push_back({1'b1, 8'hC0});
    rq[2].push_back({1'b1, 8'hC2});
    expect_byte(2, 8'hC2);
    expect_byte(0, 8'hC0);
    wait_done("ptr2_probe");

    // reset while waiting for the UART to drain
    rq[2].push_back({1'b1, 8'h33});
    expect_byte(2, 8'h33);
    for (int c = 0; c < 100 && !(busy && !uart_tx_idle && exp_q.size() == 0); c++) tick();
    tick();
    chk("pre_rst_busy", 32'(busy && !uart_tx_idle), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_start", 32'(uart_tx_start), 0);
    chk("midrst_data", 32'(uart_tx_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(req_ready), 0);
    foreach (rq[i]) rq[i] = {};
    exp_q = {};
    hs = '0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    rq[3].push_back({1'b1, 8'h7E});
    expect_byte(3, 8'h7E);
    tick();
    chk("lat_idle_grant", 32'(grant), 0);
    tick();
    chk("lat_grant", 32'(grant), 32'b1000);
    chk("lat_ready", 32'(req_ready), 32'b1000);
    tick();
    chk("lat_start", 32'(uart_tx_start), 1);
    wait_done("post_rst");

    // table of simultaneous one-byte packets
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) if (tbl[r].mask[i]) rq[i].push_back({1'b1, 8'(160 + 16*r + i)});
      for (int k = 0; k < tbl[r].n; k++) expect_byte(tbl[r].ord[k], 8'(160 + 16*r + tbl[r].ord[k]));
      wait_done($sformatf("tbl%0d", r));
    end

    // fairness: all requesters continuously valid, pointer starts at 2
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) rq[i].push_back({1'b1, 8'(16*(r+1) + i)});
    for (int k = 0; k < 8; k++) expect_byte((2 + k) % 4, 8'(16*(k/4+1) + (2 + k) % 4));
    wait_done("fair");

    // owner stall mid-packet holds the grant
    rq[3].push_back({1'b0, 8'h55});
    rq[3].push_back({1'b1, 8'h56});
    rq[0].push_back({1'b1, 8'h99});
    expect_byte(3, 8'h55);
    expect_byte(3, 8'h56);
    expect_byte(0, 8'h99);
    for (int c = 0; c < 100 && rq[3].size() != 1; c++) tick();
    chk("stall_first_sent", 32'(rq[3].size()), 1);
    en[3] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("stall_hold", {28'b0, grant} | 32'(req_ready[0]) << 8, 32'b1000);
    end
    chk("stall_busy", 32'(busy), 1);
    en[3] = 1'b1;
    wait_done("stall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
